detector_jogada: RTL and testbench

Input conditioner for the memory-game datapath: synchronizes the raw `botoes` push-buttons to `clock`, debounces them, rejects multi-button presses, and emits exactly one `tem_jogada` pulse with a registered one-hot `jogada` code per physical press. Sits directly upstream of the game circuit's `botoes`/`tem_jogada` path. The game FSM consumes `tem_jogada` as its "play made" event and `jogada` as the value compared against memory.

---
 rtl/detector_jogada_pkg.sv | 22 ++
 rtl/sincronizador.sv | 25 ++
 rtl/detector_jogada.sv | 130 +++++++++++++
 tb/tb_detector_jogada.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared types and constants for the button-press detector: FSM state
// encoding, one-hot button codes and a multi-hot test helper.
package detector_jogada_pkg;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    ESTABILIZA  = 2'd1,
    PRESSIONADO = 2'd2,
    LIBERA      = 2'd3
  } estado_t;

  localparam logic [3:0] BOTAO_0 = 4'b0001;
  localparam logic [3:0] BOTAO_1 = 4'b0010;
  localparam logic [3:0] BOTAO_2 = 4'b0100;
  localparam logic [3:0] BOTAO_3 = 4'b1000;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic mais_de_um(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear on the
// synchronous active-high reset.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments so q takes the old meta, giving two stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the four game buttons and emits one tem_jogada pulse with a
// one-hot jogada per press. Define DETECTOR_MULTIPLO_EN to discard multi-hot presses.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       tem_jogada,
  output logic [3:0] jogada,
  output logic       db_multiplo,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_SAT = '1;

  logic [3:0]    sinc;
  estado_t       estado, estado_next;
  logic [3:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          aceita;
  logic          tem_next;
  logic [3:0]    jogada_next;
  logic          multiplo_next;

  sincronizador #(.WIDTH(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (sinc)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    estado_next = estado;
    cand_next   = cand;
    cnt_next    = cnt;
    aceita      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (sinc != 4'd0) begin
          estado_next = ESTABILIZA;
          cand_next   = sinc;
          cnt_next    = '0;
        end
      end
      ESTABILIZA: begin
        if (sinc == 4'd0) begin
          estado_next = OCIOSO;
        end else if (sinc != cand) begin
          cand_next = sinc;
          cnt_next  = '0;
        end else if (cnt == CNT_MAX) begin
          estado_next = PRESSIONADO;
          aceita      = 1'b1;
        end else if (cnt != CNT_SAT) begin
          cnt_next = cnt + CW'(1);
        end
      end
      PRESSIONADO: begin
        if (sinc == 4'd0) begin
          estado_next = LIBERA;
          cnt_next    = '0;
        end
      end
      LIBERA: begin
        if (sinc != 4'd0) begin
          cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
          estado_next = OCIOSO;
        end else if (cnt != CNT_SAT) begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: estado_next = OCIOSO;
    endcase

    tem_next      = 1'b0;
    jogada_next   = jogada;
    multiplo_next = 1'b0;
`ifdef DETECTOR_MULTIPLO_EN
    if (aceita && mais_de_um(cand)) begin
      multiplo_next = 1'b1;
    end else if (aceita && habilita) begin
      tem_next    = 1'b1;
      jogada_next = cand;
    end
`else
    if (aceita && habilita) begin
      tem_next    = 1'b1;
      jogada_next = cand;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      cand       <= '0;
      cnt        <= '0;
      tem_jogada <= 1'b0;
      jogada     <= '0;
    end else begin
      estado     <= estado_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      tem_jogada <= tem_next;
      jogada     <= jogada_next;
    end
  end

`ifdef DETECTOR_MULTIPLO_EN
  always_ff @(posedge clock) begin
    if (reset) db_multiplo <= 1'b0;
    else       db_multiplo <= multiplo_next;
  end
`else
  assign db_multiplo = 1'b0;
  logic unused_multiplo;
  assign unused_multiplo = multiplo_next;
`endif

  assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed self-checking bench for detector_jogada with DEBOUNCE = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       db_multiplo;
  logic [1:0] db_estado;

  int errors = 0;
  int checks = 0;
  int calls  = 0;
  int pulses = 0;
  int mults  = 0;
  int pulse_call = -1;
  logic [3:0] pulse_jog = 4'd0;

  detector_jogada #(.DEBOUNCE(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .habilita    (habilita),
    .tem_jogada  (tem_jogada),
    .jogada      (jogada),
    .db_multiplo (db_multiplo),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample what the last rising edge produced, then drive botoes.
  task automatic cyc(input logic [3:0] b);
    @(negedge clock);
    calls++;
    if (tem_jogada === 1'b1) begin
      pulses++;
      pulse_call = calls;
      pulse_jog  = jogada;
    end
    if (db_multiplo === 1'b1) mults++;
    botoes = b;
  endtask

  task automatic press(input logic [3:0] b, input int on, input int off);
    for (int i = 0; i < on; i++) cyc(b);
    for (int i = 0; i < off; i++) cyc(4'd0);
  endtask

  logic [3:0] seq [16] = '{BOTAO_0, BOTAO_1, BOTAO_2, BOTAO_3, BOTAO_1, BOTAO_0, BOTAO_3, BOTAO_2,
                           BOTAO_2, BOTAO_0, BOTAO_1, BOTAO_3, BOTAO_0, BOTAO_2, BOTAO_3, BOTAO_1};

  initial begin
    int p0, m0, sc, rc;
    logic [3:0] jog0;
    reset    = 1'b1;
    botoes   = 4'd0;
    habilita = 1'b1;

    // Reset state
    cyc(4'd0);
    check("reset_tem", tem_jogada, 1'b0);
    check("reset_jogada", jogada, 4'd0);
    check("reset_multiplo", db_multiplo, 1'b0);
    check("reset_estado", db_estado, 2'd0);
    reset = 1'b0;
    cyc(4'd0);
    cyc(4'd0);

    // Single press of button 2: pulse observed 7 edges after the press starts
    p0 = pulses;
    sc = calls + 1;
    for (int i = 0; i < 10; i++) cyc(BOTAO_2);
    check("single_held_estado", db_estado, 2'd2);
    for (int i = 0; i < 7; i++) cyc(4'd0);
    check("single_libera_estado", db_estado, 2'd3);
    cyc(4'd0);
    check("single_ocioso_estado", db_estado, 2'd0);
    check("single_count", pulses - p0, 1);
    check("single_latency", pulse_call, sc + 7);
    check("single_pulse_jog", pulse_jog, BOTAO_2);
    press(4'd0, 0, 2);
    check("single_jog_held", jogada, BOTAO_2);

    // 3-cycle glitch is dropped
    p0 = pulses;
    press(BOTAO_1, 3, 10);
    check("glitch_count", pulses - p0, 0);
    check("glitch_jog", jogada, BOTAO_2);
    check("glitch_estado", db_estado, 2'd0);

    // Bounce then stable hold yields one pulse
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      cyc(BOTAO_0);
      cyc(4'd0);
    end
    sc = calls + 1;
    press(BOTAO_0, 10, 10);
    check("bounce_count", pulses - p0, 1);
    check("bounce_latency", pulse_call, sc + 7);
    check("bounce_jog", jogada, BOTAO_0);

    // Multi-button press
    p0 = pulses;
    m0 = mults;
    press(4'b0011, 10, 10);
`ifdef DETECTOR_MULTIPLO_EN
    check("multi_mult_count", mults - m0, 1);
    check("multi_tem_count", pulses - p0, 0);
    check("multi_jog", jogada, BOTAO_0);
`else
    check("multi_mult_count", mults - m0, 0);
    check("multi_tem_count", pulses - p0, 1);
    check("multi_jog", jogada, 4'b0011);
`endif
    jog0 = jogada;

    // Disabled press walks the FSM but produces nothing
    habilita = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) cyc(BOTAO_3);
    check("disabled_estado", db_estado, 2'd2);
    press(4'd0, 0, 10);
    check("disabled_count", pulses - p0, 0);
    check("disabled_jog", jogada, jog0);
    check("disabled_back_idle", db_estado, 2'd0);
    habilita = 1'b1;

    // Reset at cycle 5 of a press; re-debounce after reset releases
    p0 = pulses;
    for (int i = 0; i < 5; i++) cyc(BOTAO_1);
    reset = 1'b1;
    cyc(BOTAO_1);
    check("midreset_count", pulses - p0, 0);
    check("midreset_estado", db_estado, 2'd0);
    check("midreset_jog", jogada, 4'd0);
    rc = calls;
    reset = 1'b0;
    press(BOTAO_1, 10, 10);
    check("postreset_count", pulses - p0, 1);
    check("postreset_latency", pulse_call, rc + 7);
    check("postreset_jog", jogada, BOTAO_1);

    // 16-press sequence
    m0 = pulses;
    for (int k = 0; k < 16; k++) begin
      p0 = pulses;
      press(seq[k], 10, 10);
      check($sformatf("seq%0d_count", k), pulses - p0, 1);
      check($sformatf("seq%0d_jog", k), pulse_jog, seq[k]);
    end
    check("seq_total", pulses - m0, 16);
    check("seq_final_jog", jogada, BOTAO_1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
